// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch per handshake, returns the word LATENCY cycles later.
// Optional misaligned/out-of-range fault reporting is enabled by defining IMEM_ERR_CHECK_EN.
module imem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic          resp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          err_q;
  logic          accept;
  logic          enter_resp;
  logic          addr_err;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   mem [DEPTH];

`ifdef IMEM_ERR_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // With zero latency the word is read on the accept edge, so bypass the latched index.
  assign rd_idx = accept ? req_addr[AW+1:2] : idx_q;
  assign rd_err = accept ? addr_err : err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The read uses the pre-edge memory contents, so a same-edge preload is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      resp_inst <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= 4'(LATENCY);
        idx_q <= req_addr[AW+1:2];
        err_q <= addr_err;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_inst <= rd_err ? NOP_INST : mem[rd_idx];
        resp_err  <= rd_err;
      end else if (state == RESP && resp_ready) begin
        resp_inst <= 32'd0;
        resp_err  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
// Define IMEM_ERR_CHECK_EN for both bench and RTL to exercise fault reporting.
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;

  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst;

  logic        req_valid0 = 1'b0, resp_ready0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_inst0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_inst(resp_inst0), .resp_err(resp_err0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    nvec++; if (resp_inst !== 32'd0) begin nerr++; $display("[TB] FAIL reset_resp_inst: got %h expected 0", resp_inst); end
    rst = 1'b1;
    tick();
    preload(10'd4, 32'h00500093);
    req_valid = 1'b1; req_addr = 32'h10; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("[TB] FAIL wait_req_ready: got %b expected 0", req_ready); end
    #2 rst = 1'b0;
    #1;
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL midwait_reset_valid: got %b expected 0", resp_valid); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL midwait_reset_ready: got %b expected 1", req_ready); end
    tick();
    rst = 1'b1;
    tick(); tick();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL dropped_fetch_valid: got %b expected 0", resp_valid); end
  endtask

  // Accept at edge t; valid is visible after edge t+2 and handshakes at edge t+3.
  task automatic test_basic_fetch();
    req_valid = 1'b1; req_addr = 32'h10; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEC;
    tick();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL basic_early_valid: got %b expected 0", resp_valid); end
    tick();
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("[TB] FAIL basic_valid: got %b expected 1", resp_valid); end
    nvec++; if (resp_inst !== 32'h00500093) begin nerr++; $display("[TB] FAIL basic_inst: got %h expected 00500093", resp_inst); end
    nvec++; if (resp_err !== 1'b0) begin nerr++; $display("[TB] FAIL basic_err: got %b expected 0", resp_err); end
    tick();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL basic_drop_valid: got %b expected 0", resp_valid); end
    nvec++; if (resp_inst !== 32'd0) begin nerr++; $display("[TB] FAIL basic_drop_inst: got %h expected 0", resp_inst); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL basic_ready_back: got %b expected 1", req_ready); end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
      nvec++; if (resp_inst !== 32'h00500093) begin nerr++; $display("[TB] FAIL bp_inst[%0d]: got %h expected 00500093", i, resp_inst); end
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", i, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL bp_release_valid: got %b expected 0", resp_valid); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL bp_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_latency0();
    preload(10'd0, 32'hAAAA_0001);
    preload(10'd1, 32'hBBBB_0002);
    req_valid0 = 1'b1; req_addr0 = 32'h0; resp_ready0 = 1'b1;
    tick();
    nvec++; if (resp_valid0 !== 1'b1) begin nerr++; $display("[TB] FAIL l0_first_valid: got %b expected 1", resp_valid0); end
    nvec++; if (resp_inst0 !== 32'hAAAA_0001) begin nerr++; $display("[TB] FAIL l0_first_inst: got %h expected aaaa0001", resp_inst0); end
    req_addr0 = 32'h4;
    tick();
    nvec++; if (resp_valid0 !== 1'b0) begin nerr++; $display("[TB] FAIL l0_gap_valid: got %b expected 0", resp_valid0); end
    nvec++; if (req_ready0 !== 1'b1) begin nerr++; $display("[TB] FAIL l0_gap_ready: got %b expected 1", req_ready0); end
    tick();
    req_valid0 = 1'b0;
    nvec++; if (resp_valid0 !== 1'b1) begin nerr++; $display("[TB] FAIL l0_second_valid: got %b expected 1", resp_valid0); end
    nvec++; if (resp_inst0 !== 32'hBBBB_0002) begin nerr++; $display("[TB] FAIL l0_second_inst: got %h expected bbbb0002", resp_inst0); end
    tick();
    nvec++; if (resp_valid0 !== 1'b0) begin nerr++; $display("[TB] FAIL l0_end_valid: got %b expected 0", resp_valid0); end
  endtask

  task automatic test_load_collision();
    req_valid = 1'b1; req_addr = 32'h10; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 10'd4; ld_data = 32'h00A00113;
    tick();
    ld_en = 1'b0;
    nvec++; if (resp_inst !== 32'h00500093) begin nerr++; $display("[TB] FAIL collide_old_word: got %h expected 00500093", resp_inst); end
    tick();
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    nvec++; if (resp_inst !== 32'h00A00113) begin nerr++; $display("[TB] FAIL refetch_new_word: got %h expected 00a00113", resp_inst); end
    tick();
  endtask

  task automatic test_addr_range();
`ifdef IMEM_ERR_CHECK_EN
    req_valid = 1'b1; req_addr = 32'h2; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    nvec++; if (resp_err !== 1'b1) begin nerr++; $display("[TB] FAIL misalign_err: got %b expected 1", resp_err); end
    nvec++; if (resp_inst !== 32'h00000013) begin nerr++; $display("[TB] FAIL misalign_nop: got %h expected 00000013", resp_inst); end
    tick();
    req_valid = 1'b1; req_addr = 32'(DEPTH * 4);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    nvec++; if (resp_err !== 1'b1) begin nerr++; $display("[TB] FAIL range_err: got %b expected 1", resp_err); end
    nvec++; if (resp_inst !== 32'h00000013) begin nerr++; $display("[TB] FAIL range_nop: got %h expected 00000013", resp_inst); end
    tick();
`else
    req_valid = 1'b1; req_addr = 32'(DEPTH * 4); resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    nvec++; if (resp_inst !== 32'hAAAA_0001) begin nerr++; $display("[TB] FAIL wrap_inst: got %h expected aaaa0001", resp_inst); end
    nvec++; if (resp_err !== 1'b0) begin nerr++; $display("[TB] FAIL wrap_err: got %b expected 0", resp_err); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_latency0();
    test_load_collision();
    test_addr_range();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
